// File: rtl/serial_sum_receiver.sv
// Bit-serial adder: takes two operands LSB-first, one bit pair per qualified
// clock, and presents the (reglength+1)-bit sum on a valid/ready output port.
module serial_sum_receiver #(
  parameter int reglength = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 bit_valid,
  input  logic                 a_bit,
  input  logic                 b_bit,
  output logic [reglength:0]   result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy
);

  localparam int cnt_w = (reglength > 1) ? $clog2(reglength) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   carry;
  logic [cnt_w-1:0]       count;
  logic [reglength-1:0]   sum;

  logic                   s;
  logic                   carry_next;
  logic [reglength-1:0]   sum_next;
  logic                   last_bit;
  logic                   take_bit;

  // Datapath combinational terms for the bit pair currently on the inputs.
  always_comb begin
    s          = a_bit ^ b_bit ^ carry;
    carry_next = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    sum_next   = sum;
    sum_next[count] = s;
    last_bit   = (count == cnt_w'(reglength - 1));
    take_bit   = (state == RECV) && !abort && bit_valid;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Abort wins over bit_valid; start is ignored outside IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RECV;
      RECV: begin
        if (abort)                     state_next = IDLE;
        else if (bit_valid && last_bit) state_next = DONE;
      end
      DONE: if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output handshake: result_valid is high exactly while in DONE; the word is
  // taken on the first edge with result_valid && result_ready, which returns
  // the block to IDLE. result is only written on DONE entry (and by reset).
  always_comb begin
    result_valid = (state == DONE);
    busy         = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      result <= '0;
    end else if (state == IDLE && start) begin
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
    end else if (take_bit) begin
      carry <= carry_next;
      sum   <= sum_next;
      count <= last_bit ? '0 : count + cnt_w'(1);
      if (last_bit) result <= {carry_next, sum_next};
    end
  end

endmodule

// File: doc/serial_sum_receiver.md
# serial_sum_receiver

Bit-serial adder with a parallel result port: accepts two operands LSB-first, one bit pair per qualified clock, and adds them with a single carry flip-flop. It assembles a (reglength+1)-bit sum and presents it on a valid/ready handshake. It is the serial-in, parallel-out counterpart to the team's parallel-in, serial-out summator, for links where operands arrive as serial streams and the consumer needs a parallel word.

## Interface
- reglength, default 3, operand width in bits (legal ≥ 1); result width is reglength+1.

- clk  input  1  single clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  frame start pulse; honoured only in IDLE.
- abort  input  1  drops an in-progress frame; honoured only in RECV.
- bit_valid  input  1  qualifies a_bit/b_bit in RECV.
- a_bit  input  1  operand A serial bit, LSB-first.
- b_bit  input  1  operand B serial bit, LSB-first.
- result  output  reglength+1  assembled sum; bit reglength is the final carry.
- result_valid  output  1  result is held and valid.
- result_ready  input  1  consumer accepts result.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, RECV, DONE. Encoding is free; the transitions below are mandatory.
- IDLE:
  - start=1 → RECV.
  - On that same edge: carry←0, bit counter←0, sum shift register←0.
  - a_bit, b_bit and bit_valid are ignored in the start cycle.
- RECV, each edge with bit_valid=1 and abort=0:
  - s = a_bit ^ b_bit ^ carry.
  - carry ← majority(a_bit, b_bit, carry).
  - s is written at sum bit index = counter; counter increments.
- RECV, bit_valid=0: counter, carry and sum are held. Stalls of any length are legal.
- Last bit: on the edge that consumes bit index reglength-1:
  - result ← {carry_next, sum bits with s inserted}.
  - result_valid ← 1.
  - state → DONE.
- RECV, abort=1: → IDLE. Abort takes priority over bit_valid. result and result_valid are unchanged (result keeps its previous value).
- DONE:
  - result and result_valid are held stable.
  - result_ready=1 → IDLE, and result_valid ← 0 on the same edge.
  - start is ignored in DONE, including when it coincides with result_ready. A new frame needs start in IDLE, one cycle after the handshake at the earliest.
- Width rules: the counter is wide enough to hold reglength-1. Arithmetic is unsigned. Overflow never occurs, because the carry lands in result[reglength].
- result changes only on the DONE-entry edge and on reset.

## Timing
- Reset (asynchronous assert, any cycle): state=IDLE, result=0, result_valid=0, busy=0, carry=0, counter=0. Outputs take these values immediately on rst_n falling, without waiting for clk.
- Reset mid-frame or while in DONE discards all data; no partial result is presented.
- Latency, continuous bit_valid:
  - start sampled at edge 0; bits sampled at edges 1…reglength.
  - result_valid is high after edge reglength; that frame's result is stable in the same cycle.
- busy rises after the start edge and falls after the handshake or abort edge.
- Throughput: one frame per reglength+2 cycles minimum (start, bits, handshake).
- result_valid never drops without result_ready=1 sampled at an edge, or without reset.

## Test plan
- reglength=3, start then bits A=5 (1,0,1), B=6 (0,1,1), bit_valid continuous, result_ready=1 → result_valid high after edge 3 with result=4'b1011 (11); result_valid low after the next edge; busy low.
- A=7, B=7 with bit_valid gaps of 2 cycles between each bit → result=4'b1110 (14). result_valid rises only after the third qualified bit; no change during the gaps.
- Backpressure: complete a frame with A=3, B=1, hold result_ready=0 for 5 cycles and pulse start during DONE → result=4'b0100 held stable and valid throughout; start ignored. Raise result_ready → IDLE. Next start accepted.
- Abort: start, feed 2 bits, assert abort with bit_valid=1 → IDLE, busy=0, result_valid stays 0. Next frame A=2, B=2 → result=4'b0100, with no residue from the aborted frame.
- Async reset: assert rst_n=0 mid-RECV between clock edges → outputs go to 0 immediately. After release, a full frame A=1, B=1 → result=4'b0010.
- reglength=1 build: A=1, B=1 → result=2'b10 after edge 1; A=0, B=1 → 2'b01.
